// File: rtl/mtpsa_tenant_arbiter.sv
// Packet-granular round-robin arbiter merging tenant AXI-Stream inputs into one SDNet stream.
// Zero-latency datapath; one IDLE arbitration cycle between packets.
module mtpsa_tenant_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned USER_WIDTH = 128,
  localparam int unsigned IdWidth   = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1,
  localparam int unsigned KeepWidth = DATA_WIDTH / 8
) (
  input  logic                            axis_aclk,
  input  logic                            axis_reset,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*KeepWidth-1:0]  s_axis_tkeep,
  input  logic [NUM_PORTS*USER_WIDTH-1:0] s_axis_tuser,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [KeepWidth-1:0]            m_axis_tkeep,
  output logic [USER_WIDTH-1:0]           m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic                            m_tuple_valid,
  output logic [IdWidth-1:0]              m_tenant_id
);

  if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : gen_bad_num_ports
    $error("NUM_PORTS must be in 2..8");
  end

  typedef enum logic {StIdle, StPkt} state_e;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [IdWidth-1:0]   r_grant;
  logic [IdWidth-1:0]   r_last_grant;
  logic                 r_first_beat;
  logic [IdWidth-1:0]   w_sel;
  logic                 w_found;
  logic [DATA_WIDTH-1:0] w_tdata;
  logic [KeepWidth-1:0] w_tkeep;
  logic [USER_WIDTH-1:0] w_tuser;
  logic                 w_tvalid;
  logic                 w_tlast;
  logic                 w_hs;
  logic                 w_start;
  logic                 w_end;

  // Round-robin: ports above last_grant first, then wrap to ports at or below it.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (!w_found && (IdWidth'(p) > r_last_grant) && s_axis_tvalid[p]) begin
        w_sel   = IdWidth'(p);
        w_found = 1'b1;
      end
    end
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (!w_found && (IdWidth'(p) <= r_last_grant) && s_axis_tvalid[p]) begin
        w_sel   = IdWidth'(p);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_tdata  = '0;
    w_tkeep  = '0;
    w_tuser  = '0;
    w_tvalid = 1'b0;
    w_tlast  = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (r_grant == IdWidth'(p)) begin
        w_tdata  = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
        w_tkeep  = s_axis_tkeep[p*KeepWidth +: KeepWidth];
        w_tuser  = s_axis_tuser[p*USER_WIDTH +: USER_WIDTH];
        w_tvalid = s_axis_tvalid[p];
        w_tlast  = s_axis_tlast[p];
      end
    end
  end

  always_comb begin
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    if (r_state == StPkt) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (r_grant == IdWidth'(p)) begin
          s_axis_tready[p] = m_axis_tready;
        end
      end
      m_axis_tdata  = w_tdata;
      m_axis_tkeep  = w_tkeep;
      m_axis_tuser  = w_tuser;
      m_axis_tvalid = w_tvalid;
      m_axis_tlast  = w_tvalid & w_tlast;
    end
  end

  assign w_hs          = m_axis_tvalid & m_axis_tready;
  assign m_tuple_valid = r_first_beat & w_hs;
  assign m_tenant_id   = r_grant;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (|s_axis_tvalid) w_state_nxt = StPkt;
      StPkt:   if (w_hs && m_axis_tlast) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_start = (r_state == StIdle) && (w_state_nxt == StPkt);
  assign w_end   = (r_state == StPkt) && (w_state_nxt == StIdle);

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      r_state      <= StIdle;
      r_grant      <= '0;
      r_last_grant <= IdWidth'(NUM_PORTS - 1);
      r_first_beat <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_grant      <= w_sel;
        r_first_beat <= 1'b1;
      end else if (w_hs) begin
        r_first_beat <= 1'b0;
      end
      if (w_end) begin
        r_last_grant <= r_grant;
      end
    end
  end

  a_ready_onehot: assert property (@(posedge axis_aclk) disable iff (axis_reset)
    $onehot0(s_axis_tready));
  a_last_needs_valid: assert property (@(posedge axis_aclk) disable iff (axis_reset)
    m_axis_tlast |-> m_axis_tvalid);

endmodule

// File: tb/tb_mtpsa_tenant_arbiter.sv
// Directed self-checking bench for mtpsa_tenant_arbiter (4 tenants, default widths).
module tb_mtpsa_tenant_arbiter;
  localparam int unsigned NP = 4;
  localparam int unsigned DW = 256;
  localparam int unsigned UW = 128;
  localparam int unsigned KW = DW / 8;

  logic             axis_aclk = 1'b0;
  logic             axis_reset = 1'b0;
  logic [NP*DW-1:0] s_axis_tdata;
  logic [NP*KW-1:0] s_axis_tkeep;
  logic [NP*UW-1:0] s_axis_tuser;
  logic [NP-1:0]    s_axis_tvalid;
  logic [NP-1:0]    s_axis_tlast;
  logic [NP-1:0]    s_axis_tready;
  logic [DW-1:0]    m_axis_tdata;
  logic [KW-1:0]    m_axis_tkeep;
  logic [UW-1:0]    m_axis_tuser;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tready;
  logic             m_tuple_valid;
  logic [1:0]       m_tenant_id;

  always #5 axis_aclk = ~axis_aclk;

  mtpsa_tenant_arbiter #(
    .NUM_PORTS (NP),
    .DATA_WIDTH(DW),
    .USER_WIDTH(UW)
  ) dut (
    .axis_aclk    (axis_aclk),
    .axis_reset   (axis_reset),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .m_tuple_valid(m_tuple_valid),
    .m_tenant_id  (m_tenant_id)
  );

  typedef struct {
    int          id;
    logic [23:0] data;
    logic [31:0] keep;
    logic [15:0] user;
    bit          tuple;
    bit          last;
    int          cyc;
  } hs_t;

  // Tenant source model: beats left in current packet, optional follow-on packet.
  int  src_rem[NP];
  int  src_more[NP];
  int  src_beat[NP];
  int  src_pkt[NP];
  bit  src_hold[NP];
  bit  want_ready;
  hs_t log_q[$];
  int  n_checks;
  int  n_pass;
  int  n_tuple;
  int  cyc;
  logic [NP-1:0] obs_tready;
  logic          obs_mvalid;
  logic [1:0]    obs_id;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < NP; p++) begin
      s_axis_tvalid[p]         = (src_rem[p] > 0) && !src_hold[p];
      s_axis_tlast[p]          = (src_rem[p] == 1);
      s_axis_tdata[p*DW +: DW] = DW'({8'(src_pkt[p]), 8'(p), 8'(src_beat[p])});
      s_axis_tkeep[p*KW +: KW] = KW'(p + 1);
      s_axis_tuser[p*UW +: UW] = UW'((p << 8) | src_pkt[p]);
    end
    m_axis_tready = want_ready;
  endtask

  task automatic step();
    @(negedge axis_aclk);
    drive_inputs();
    #1;
    obs_tready = s_axis_tready;
    obs_mvalid = m_axis_tvalid;
    obs_id     = m_tenant_id;
    if (m_tuple_valid) n_tuple++;
    if (m_axis_tvalid && m_axis_tready) begin
      log_q.push_back('{int'(m_tenant_id), m_axis_tdata[23:0], m_axis_tkeep, m_axis_tuser[15:0],
                        m_tuple_valid, m_axis_tlast, cyc});
    end
    for (int p = 0; p < NP; p++) begin
      if (s_axis_tvalid[p] && s_axis_tready[p]) begin
        src_rem[p]--;
        src_beat[p]++;
        if (src_rem[p] == 0) begin
          src_beat[p] = 0;
          src_pkt[p]++;
          src_rem[p]  = src_more[p];
          src_more[p] = 0;
        end
      end
    end
    cyc++;
  endtask

  task automatic wait_hs(input string tag, input int n, input int bound);
    int k = 0;
    while (log_q.size() < n && k < bound) begin
      step();
      k++;
    end
    check_eq({tag, "_hs_count"}, 64'(log_q.size()), 64'(n));
  endtask

  task automatic do_reset();
    axis_reset = 1'b1;
    for (int p = 0; p < NP; p++) begin
      src_rem[p]  = 0;
      src_more[p] = 0;
      src_beat[p] = 0;
      src_pkt[p]  = 0;
      src_hold[p] = 1'b0;
    end
    want_ready = 1'b1;
    log_q.delete();
    n_tuple = 0;
    drive_inputs();
    repeat (2) @(negedge axis_aclk);
    axis_reset = 1'b0;
  endtask

  initial begin
    int          ports[5];
    logic [23:0] exp_data;
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    ports    = '{0, 1, 2, 3, 0};
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b0;

    // Reset state with requests and ready already high.
    #2;
    axis_reset    = 1'b1;
    s_axis_tvalid = 4'hF;
    s_axis_tlast  = 4'hF;
    m_axis_tready = 1'b1;
    #1;
    check_eq("rst_tready", 64'(s_axis_tready), 64'(0));
    check_eq("rst_mvalid", 64'(m_axis_tvalid), 64'(0));
    check_eq("rst_mlast", 64'(m_axis_tlast), 64'(0));
    check_eq("rst_tuple", 64'(m_tuple_valid), 64'(0));
    check_eq("rst_id", 64'(m_tenant_id), 64'(0));
    do_reset();

    // All four tenants with 3-beat packets; port 0 has a second packet queued.
    for (int p = 0; p < NP; p++) src_rem[p] = 3;
    src_more[0] = 3;
    wait_hs("t1", 15, 80);
    if (log_q.size() >= 15) begin
      for (int i = 0; i < 15; i++) begin
        exp_data = {8'((i / 3 == 4) ? 1 : 0), 8'(ports[i / 3]), 8'(i % 3)};
        check_eq($sformatf("t1_id%0d", i), 64'(log_q[i].id), 64'(ports[i / 3]));
        check_eq($sformatf("t1_data%0d", i), 64'(log_q[i].data), 64'(exp_data));
        check_eq($sformatf("t1_keep%0d", i), 64'(log_q[i].keep), 64'(ports[i / 3] + 1));
        check_eq($sformatf("t1_user%0d", i), 64'(log_q[i].user),
                 64'((ports[i / 3] << 8) | ((i / 3 == 4) ? 1 : 0)));
        check_eq($sformatf("t1_tuple%0d", i), 64'(log_q[i].tuple), 64'(i % 3 == 0));
        check_eq($sformatf("t1_last%0d", i), 64'(log_q[i].last), 64'(i % 3 == 2));
      end
      for (int k = 1; k < 5; k++) begin
        check_eq($sformatf("t1_gap%0d", k), 64'(log_q[3*k].cyc - log_q[3*k-1].cyc), 64'(2));
      end
    end
    check_eq("t1_tuple_count", 64'(n_tuple), 64'(5));

    // Port 2 single-beat packet alone.
    do_reset();
    src_rem[2] = 1;
    wait_hs("t2", 1, 10);
    if (log_q.size() >= 1) begin
      check_eq("t2_id", 64'(log_q[0].id), 64'(2));
      check_eq("t2_tuple", 64'(log_q[0].tuple), 64'(1));
      check_eq("t2_last", 64'(log_q[0].last), 64'(1));
    end
    step();
    check_eq("t2_idle_tready", 64'(obs_tready), 64'(0));
    check_eq("t2_idle_mvalid", 64'(obs_mvalid), 64'(0));
    check_eq("t2_idle_id_hold", 64'(obs_id), 64'(2));

    // Port 1 4-beat packet under periodic backpressure.
    do_reset();
    src_rem[1] = 4;
    for (int i = 0; i < 30; i++) begin
      want_ready = (i % 3 == 0);
      step();
    end
    check_eq("t3_hs_count", 64'(log_q.size()), 64'(4));
    if (log_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check_eq($sformatf("t3_data%0d", i), 64'(log_q[i].data), 64'({8'(0), 8'(1), 8'(i)}));
        check_eq($sformatf("t3_tuple%0d", i), 64'(log_q[i].tuple), 64'(i == 0));
      end
    end
    check_eq("t3_tuple_count", 64'(n_tuple), 64'(1));

    // Port 0 stalls mid-packet while port 3 waits.
    do_reset();
    src_rem[0] = 6;
    src_rem[3] = 2;
    wait_hs("t4a", 2, 10);
    src_hold[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq($sformatf("t4_stall_mvalid%0d", i), 64'(obs_mvalid), 64'(0));
      check_eq($sformatf("t4_stall_rdy3_%0d", i), 64'(obs_tready[3]), 64'(0));
      check_eq($sformatf("t4_stall_id%0d", i), 64'(obs_id), 64'(0));
    end
    src_hold[0] = 1'b0;
    wait_hs("t4b", 8, 40);
    if (log_q.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        check_eq($sformatf("t4_id%0d", i), 64'(log_q[i].id), 64'((i < 6) ? 0 : 3));
      end
      check_eq("t4_p0_last", 64'(log_q[5].last), 64'(1));
    end

    // Reset in the middle of a 5-beat packet, then ports 0 and 2 compete.
    do_reset();
    src_rem[0] = 5;
    wait_hs("t5a", 2, 10);
    @(negedge axis_aclk);
    drive_inputs();
    #1;
    check_eq("t5_pre_mvalid", 64'(m_axis_tvalid), 64'(1));
    check_eq("t5_pre_beat", 64'(m_axis_tdata[7:0]), 64'(2));
    axis_reset = 1'b1;
    #1;
    check_eq("t5_rst_tready", 64'(s_axis_tready), 64'(0));
    check_eq("t5_rst_mvalid", 64'(m_axis_tvalid), 64'(0));
    check_eq("t5_rst_mlast", 64'(m_axis_tlast), 64'(0));
    check_eq("t5_rst_tuple", 64'(m_tuple_valid), 64'(0));
    check_eq("t5_rst_id", 64'(m_tenant_id), 64'(0));
    do_reset();
    src_rem[0] = 2;
    src_rem[2] = 2;
    wait_hs("t5b", 4, 20);
    if (log_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check_eq($sformatf("t5_id%0d", i), 64'(log_q[i].id), 64'((i < 2) ? 0 : 2));
      end
      check_eq("t5_first_beat", 64'(log_q[0].data), 64'({8'(0), 8'(0), 8'(0)}));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
